// File: rtl/thermo_pkg.sv
// Shared types and default tuning for the thermostat request generator.
package thermo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int DEF_TEMP_W      = 12;
    localparam int DEF_THRESH      = 20;
    localparam int DEF_HYST        = 5;
    localparam int DEF_MIN_RUN_CYC = 8;
    localparam int DEF_MIN_OFF_CYC = 4;

    // Two guard bits keep target + THRESH +/- HYST from wrapping.
    function automatic int cmp_w(input int temp_w);
        return temp_w + 2;
    endfunction

    localparam int DEF_CMP_W = cmp_w(DEF_TEMP_W);

endpackage

// File: rtl/thermo_timer.sv
// Loadable down-counter shared by the minimum-run and minimum-off intervals.
module thermo_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/thermostat_ctrl.sv
// Hysteretic heat/cool request FSM with minimum run time and fixed-length off lockout.
module thermostat_ctrl
    import thermo_pkg::*;
#(
    parameter int TEMP_W      = DEF_TEMP_W,
    parameter int THRESH      = DEF_THRESH,
    parameter int HYST        = DEF_HYST,
    parameter int MIN_RUN_CYC = DEF_MIN_RUN_CYC,
    parameter int MIN_OFF_CYC = DEF_MIN_OFF_CYC
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic signed [TEMP_W-1:0] target,
    input  logic signed [TEMP_W-1:0] ambient,
    output logic                     A,
    output logic                     B,
    output logic                     lockout
);

    localparam int CW   = cmp_w(TEMP_W);
    localparam int TMAX = (MIN_RUN_CYC > MIN_OFF_CYC) ? MIN_RUN_CYC : MIN_OFF_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic signed [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic signed [CW-1:0] HYST_C   = CW'(HYST);
    localparam logic [TW-1:0]        RUN_LD   = TW'(MIN_RUN_CYC);
    localparam logic [TW-1:0]        OFF_LD   = TW'(MIN_OFF_CYC - 1);

    logic signed [CW-1:0] amb_x;
    logic signed [CW-1:0] sp;
    logic signed [CW-1:0] lo;
    logic signed [CW-1:0] hi;

    assign amb_x = CW'(ambient);
    assign sp    = CW'(target) + THRESH_C;
    assign lo    = sp - HYST_C;
    assign hi    = sp + HYST_C;

    state_t        state_q;
    state_t        state_d;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    thermo_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (1'b1),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (enable && sample_valid) begin
                    if (amb_x < lo) begin
                        state_d  = HEAT;
                        tmr_load = 1'b1;
                        tmr_val  = RUN_LD;
                    end else if (amb_x > hi) begin
                        state_d  = COOL;
                        tmr_load = 1'b1;
                        tmr_val  = RUN_LD;
                    end
                end
            end
            HEAT: begin
                if (!enable || (sample_valid && tmr_zero && (amb_x >= sp))) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LD;
                end
            end
            COOL: begin
                if (!enable || (sample_valid && tmr_zero && (amb_x <= sp))) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LD;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign A       = (state_q == HEAT);
    assign B       = (state_q == COOL);
    assign lockout = (state_q == HOLD);

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed scoreboard bench for thermostat_ctrl: expected {A,B,lockout} per cycle.
module tb_thermostat_ctrl;

    localparam int TEMP_W = 12;

    logic                     clock = 1'b0;
    logic                     rst;
    logic                     enable;
    logic                     sample_valid;
    logic signed [TEMP_W-1:0] target;
    logic signed [TEMP_W-1:0] ambient;
    logic                     A;
    logic                     B;
    logic                     lockout;

    always #5 clock = ~clock;

    thermostat_ctrl #(
        .TEMP_W      (TEMP_W),
        .THRESH      (20),
        .HYST        (5),
        .MIN_RUN_CYC (8),
        .MIN_OFF_CYC (4)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .target       (target),
        .ambient      (ambient),
        .A            (A),
        .B            (B),
        .lockout      (lockout)
    );

    typedef struct {
        int       cyc;
        logic [2:0] exp;
        string    name;
    } ent_t;

    ent_t q[$];
    ent_t e;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops every entry due by this cycle and checks outputs mid-cycle.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc || {A, B, lockout} !== e.exp) begin
                n_bad++;
                $display("FAIL %s: cyc %0d ABL=%b required %b (due cyc %0d)",
                         e.name, cyc, {A, B, lockout}, e.exp, e.cyc);
            end
        end
    end

    task automatic step(input logic r, input logic en, input logic sv,
                        input int tgt, input int amb,
                        input logic [2:0] exp, input string nm);
        ent_t x;
        rst          = r;
        enable       = en;
        sample_valid = sv;
        target       = TEMP_W'(tgt);
        ambient      = TEMP_W'(amb);
        x.cyc  = cyc + 1;
        x.exp  = exp;
        x.name = nm;
        q.push_back(x);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; sample_valid = 1'b0; target = '0; ambient = '0;
        @(posedge clock);
        #1;

        // Reset wins even with a heat-worthy sample present.
        step(1, 1, 1, 0, 0,   3'b000, "rst_0");
        step(1, 1, 1, 0, 0,   3'b000, "rst_1");
        step(0, 1, 0, 0, 0,   3'b000, "post_rst_0");
        step(0, 1, 0, 0, 0,   3'b000, "post_rst_1");

        // Cool entry (sp=200, hi=205), min run, then 4-cycle hold.
        step(0, 1, 1, 180, 260, 3'b010, "cool_entry");
        step(0, 1, 0, 180, 260, 3'b010, "cool_c1");
        step(0, 1, 0, 180, 260, 3'b010, "cool_c2");
        step(0, 1, 1, 180, 200, 3'b010, "cool_early_sample");
        for (int i = 4; i <= 8; i++) step(0, 1, 0, 180, 200, 3'b010, "cool_run");
        step(0, 1, 1, 180, 200, 3'b001, "cool_exit_hold0");
        step(0, 1, 0, 180, 200, 3'b001, "hold1");
        step(0, 1, 1, 180, 100, 3'b001, "hold2_sample_ignored");
        step(0, 1, 0, 180, 200, 3'b001, "hold3");
        step(0, 1, 0, 180, 200, 3'b000, "hold_to_idle");

        // Deadband [195,205] inclusive.
        step(0, 1, 1, 180, 196, 3'b000, "db_196");
        step(0, 1, 1, 180, 205, 3'b000, "db_hi_edge");
        step(0, 1, 1, 180, 195, 3'b000, "db_lo_edge");
        step(0, 1, 1, 180, 194, 3'b100, "heat_entry_194");
        step(0, 1, 0, 180, 194, 3'b100, "heat_c1");

        // Disable mid-heat forces hold, then no re-entry while disabled.
        step(0, 0, 0, 180, 194, 3'b001, "dis_hold0");
        step(0, 0, 1, 180, 100, 3'b001, "dis_hold1");
        step(0, 0, 1, 180, 100, 3'b001, "dis_hold2");
        step(0, 0, 1, 180, 100, 3'b001, "dis_hold3");
        step(0, 0, 1, 180, 100, 3'b000, "dis_idle0");
        step(0, 0, 1, 180, 100, 3'b000, "dis_idle1");

        // Width edge: sp=2067 must not wrap negative.
        step(0, 1, 1, 2047, 2047, 3'b100, "width_heat");
        step(0, 1, 0, 2047, 2047, 3'b100, "width_heat_c1");

        // Reset mid-heat drops straight to idle, no hold.
        step(1, 1, 0, 2047, 2047, 3'b000, "rst_mid_heat");
        step(0, 1, 0, 2047, 2047, 3'b000, "after_rst_idle");

        repeat (3) @(posedge clock);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
